// File: rtl/softmax_argmax_et_if.sv
// Bundle of the vector-in / decision-out handshakes of softmax_argmax_et.
// Valid/ready: a transfer happens at a rising edge where valid and ready are both high; valid may not drop and payload may not change while it waits for ready.
interface softmax_argmax_et_if #(
   parameter int N_CLASS  = 8,
   parameter int BIT_PROB = 16,
   parameter int IDX_W    = 3
);
   logic                         in_valid;
   logic                         in_ready;
   logic [BIT_PROB*N_CLASS-1:0]  prob;
   logic [BIT_PROB-1:0]          threshold;
   logic [BIT_PROB-1:0]          margin;
   logic                         out_valid;
   logic                         out_ready;
   logic [IDX_W-1:0]             class_idx;
   logic [BIT_PROB-1:0]          max_prob;
   logic                         terminate;

   modport slave (
      input  in_valid, prob, threshold, margin, out_ready,
      output in_ready, out_valid, class_idx, max_prob, terminate
   );

   modport master (
      output in_valid, prob, threshold, margin, out_ready,
      input  in_ready, out_valid, class_idx, max_prob, terminate
   );
endinterface

// File: rtl/softmax_argmax_et.sv
// Serial argmax over one softmax vector: one class per cycle, tracks best and
// second-best, and raises an early-termination flag on confident winners.
module softmax_argmax_et #(
   parameter int N_CLASS  = 8,
   parameter int BIT_PROB = 16,
   parameter int IDX_W    = 3
) (
   input  logic              clock,
   input  logic              reset,
   softmax_argmax_et_if.slave bus,
   output logic [1:0]        dbg_state
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                      state, state_next;
   logic [BIT_PROB*N_CLASS-1:0] prob_q;
   logic [BIT_PROB-1:0]         prob_arr [N_CLASS];
   logic [BIT_PROB-1:0]         thr_q, mar_q, best, second, p_cur;
   logic [IDX_W-1:0]            idx, cnt;
   logic                        accept, last;

   always_comb begin
      for (int i = 0; i < N_CLASS; i++) begin
         prob_arr[i] = prob_q[i*BIT_PROB +: BIT_PROB];
      end
   end

   assign p_cur  = prob_arr[cnt];
   assign accept = (state == IDLE) && !reset && bus.in_valid;
   assign last   = (cnt == IDX_W'(N_CLASS - 1));

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next    = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = !reset;
            if (accept) state_next = SCAN;
         end
         SCAN: begin
            if (last) state_next = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Strict compares keep the lowest index on ties; an equal top score lands in second.
   always_ff @(posedge clock) begin
      if (reset) begin
         prob_q <= '0;
         thr_q  <= '0;
         mar_q  <= '0;
         best   <= '0;
         second <= '0;
         idx    <= '0;
         cnt    <= '0;
      end else if (accept) begin
         prob_q <= bus.prob;
         thr_q  <= bus.threshold;
         mar_q  <= bus.margin;
         best   <= '0;
         second <= '0;
         idx    <= '0;
         cnt    <= '0;
      end else if (state == SCAN) begin
         if (p_cur > best) begin
            second <= best;
            best   <= p_cur;
            idx    <= cnt;
         end else if (p_cur > second) begin
            second <= p_cur;
         end
         cnt <= cnt + 1'b1;
      end
   end

   // best >= second always holds, so the gap never wraps.
   assign bus.terminate = (state == DONE) && (best >= thr_q) && ((best - second) >= mar_q);
   assign bus.class_idx = idx;
   assign bus.max_prob  = best;
   assign dbg_state     = state;
endmodule

// File: tb/tb_softmax_argmax_et.sv
// Randomized and directed bench for softmax_argmax_et: driver pushes the model's
// answer into a queue at acceptance, a negedge monitor pops and compares.
module tb_softmax_argmax_et;
   localparam int N  = 8;
   localparam int BP = 16;
   localparam int IW = 3;
   localparam int PW = BP * N;
   localparam int EW = IW + BP + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;

   softmax_argmax_et_if #(.N_CLASS(N), .BIT_PROB(BP), .IDX_W(IW)) bus ();

   softmax_argmax_et #(.N_CLASS(N), .BIT_PROB(BP), .IDX_W(IW)) dut (
      .clock     (clk),
      .reset     (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [EW-1:0] exp_q [$];
   int unsigned acc_q [$];
   int unsigned done_cyc = 0;
   int unsigned acc_last = 0;
   bit          first_seen = 0;
   bit          rand_bp = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: sort descending for best/second, first index holding best wins.
   function automatic logic [EW-1:0] model(input logic [PW-1:0] p,
                                          input logic [BP-1:0] thr,
                                          input logic [BP-1:0] mar);
      int unsigned v [$];
      int unsigned s [$];
      int unsigned best, sec, bi;
      logic term;
      for (int i = 0; i < N; i++) v.push_back(int'(p[i*BP +: BP]));
      s = v;
      s.rsort();
      best = s[0];
      sec  = s[1];
      bi   = 0;
      for (int i = N - 1; i >= 0; i--) if (v[i] == best) bi = i;
      term = (best >= thr) && ((best - sec) >= mar);
      return {bi[IW-1:0], best[BP-1:0], term};
   endfunction

   function automatic logic [PW-1:0] pack(input int unsigned c [N]);
      logic [PW-1:0] r;
      for (int i = 0; i < N; i++) r[i*BP +: BP] = c[i][BP-1:0];
      return r;
   endfunction

   function automatic logic [PW-1:0] rand_vec(input int mode);
      logic [PW-1:0] r;
      for (int i = 0; i < N; i++) begin
         case (mode)
            0:       r[i*BP +: BP] = BP'($urandom_range(0, 65535));
            1:       r[i*BP +: BP] = BP'($urandom_range(0, 3));
            default: r[i*BP +: BP] = BP'($urandom_range(0, 200));
         endcase
      end
      if (mode == 2) r[$urandom_range(0, N-1)*BP +: BP] = BP'($urandom_range(30000, 65535));
      return r;
   endfunction

   // ---------------- driver ----------------
   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [PW-1:0] p, input logic [BP-1:0] thr, input logic [BP-1:0] mar);
      int guard = 0;
      bus.in_valid  = 1'b1;
      bus.prob      = p;
      bus.threshold = thr;
      bus.margin    = mar;
      @(negedge clk);
      while (!bus.in_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", guard);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      exp_q.push_back(model(p, thr, mar));
      #1;
      bus.in_valid  = 1'b0;
      bus.prob      = rand_vec(0);
      bus.threshold = BP'($urandom);
      bus.margin    = BP'($urandom);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      exp_q.delete();
      acc_q.delete();
      first_seen = 0;
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_class_idx", bus.class_idx, 0);
      check("rst_max_prob", bus.max_prob, 0);
      check("rst_terminate", bus.terminate, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", bus.in_ready, 1);
      check("post_rst_out_valid", bus.out_valid, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 2000) begin
         @(posedge clk);
         g++;
      end
      #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.in_valid && bus.in_ready) begin
            acc_q.push_back(cyc + 1);
            acc_last = cyc + 1;
         end
         if (bus.out_valid) begin
            check("in_ready_while_done", bus.in_ready, 0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
               if (!first_seen) begin
                  first_seen = 1;
                  if (acc_q.size() != 0) check("latency", cyc - acc_q.pop_front(), N);
               end
               check("class_idx", bus.class_idx, exp_q[0][EW-1 -: IW]);
               check("max_prob", bus.max_prob, exp_q[0][BP:1]);
               check("terminate", bus.terminate, exp_q[0][0]);
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  first_seen = 0;
                  done_cyc = cyc + 1;
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rand_bp) #1 bus.out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int unsigned v [N];
      int g;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.prob      = '0;
      bus.threshold = '0;
      bus.margin    = '0;
      bus.out_ready = 1'b1;
      #1;
      do_reset(3);

      v = '{100, 200, 50, 60000, 10, 0, 5, 30};
      send(pack(v), 16'd40000, 16'd1000);
      v = '{100, 100, 30000, 100, 100, 30000, 100, 100};
      send(pack(v), 16'd20000, 16'd1);
      v = '{1, 2, 3, 4, 5, 6, 10, 500};
      send(pack(v), 16'd1000, 16'd0);
      v = '{0, 0, 0, 0, 0, 0, 0, 0};
      send(pack(v), 16'd0, 16'd0);
      send(pack(v), 16'd0, 16'd1);
      v = '{65535, 7, 7, 7, 7, 7, 7, 65535};
      send(pack(v), 16'd65535, 16'd0);
      wait_drain();

      // Backpressure: hold the result, queue the next vector behind it.
      bus.out_ready = 1'b0;
      v = '{9, 8, 7, 6, 5, 4, 3, 40000};
      send(pack(v), 16'd100, 16'd30000);
      fork
         send(rand_vec(2), 16'd1000, 16'd500);
      join_none
      repeat (30) @(posedge clk);
      #1 bus.out_ready = 1'b1;
      g = 0;
      while (exp_q.size() > 1 && g < 100) begin
         @(posedge clk);
         g++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("next_accept_gap", acc_last, done_cyc + 1);
      wait_drain();

      // Reset lands on the edge that would examine class 4.
      v = '{1, 2, 3, 4, 50000, 6, 7, 8};
      send(pack(v), 16'd0, 16'd0);
      repeat (4) @(posedge clk);
      #1;
      do_reset(2);
      v = '{10, 20, 30, 40, 50, 60, 70, 5};
      send(pack(v), 16'd60, 16'd5);
      wait_drain();

      rand_bp = 1;
      for (int k = 0; k < 40; k++) begin
         send(rand_vec($urandom_range(0, 2)), BP'($urandom_range(0, 65535)),
              BP'($urandom_range(0, 20000)));
      end
      rand_bp = 0;
      @(posedge clk);
      #2 bus.out_ready = 1'b1;
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/softmax_argmax_et.md
# softmax_argmax_et

Classification decision stage directly downstream of the softmax kernel. Accepts one `DENSE_KSIZE`-wide vector of unsigned softmax probabilities and scans it serially, one class per cycle, for the best and second-best scores. It reports the winning class index, its probability, and an early-termination flag. The flag tells the network controller that confidence is high enough to stop further inference.

## Interface
- N_CLASS, 8: number of classes; matches `DENSE_KSIZE`; must be ≥ 2.
- BIT_PROB, 16: width of one probability; matches `BIT_SOFTMAX`.
- IDX_W, 3: width of the class index; equals clog2(N_CLASS).
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  a probability vector is presented.
- in_ready  out  1  block can accept a vector.
- prob  in  BIT_PROB*N_CLASS  packed probabilities, unsigned; class i occupies [BIT_PROB*(i+1)-1 : BIT_PROB*i].
- threshold  in  BIT_PROB  minimum winning probability for termination; unsigned.
- margin  in  BIT_PROB  minimum (best − second) gap for termination; unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- class_idx  out  IDX_W  index of the highest probability.
- max_prob  out  BIT_PROB  highest probability.
- terminate  out  1  early-termination decision.

## Operation
- FSM states:
  - IDLE: in_ready = 1 (0 while reset is high). On in_valid & in_ready:
    - latch prob, threshold and margin into internal registers;
    - clear best, second, idx and cnt to 0;
    - go to SCAN.
  - SCAN: each cycle examines latched class p = prob[cnt].
    - If p > best: second ← best, best ← p, idx ← cnt.
    - Else if p > second: second ← p.
    - cnt increments by 1. When the cycle with cnt = N_CLASS−1 completes, go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- Comparisons are strict and unsigned. On ties the lowest index wins. Equal top scores give second = best.
- terminate = (best ≥ threshold) && ((best − second) ≥ margin), using the latched threshold and margin.
  - The subtraction is BIT_PROB-bit unsigned; best ≥ second always holds, so it never underflows.
- class_idx = idx and max_prob = best, driven from registers.
- All three outputs are stable for the whole of DONE.
- Changes to prob, threshold or margin after acceptance have no effect on the current result.
- in_ready is low in SCAN and DONE. No overlap between vectors.
- All-zero vector: class_idx = 0, max_prob = 0, second = 0.
  - terminate = 1 only if threshold = 0 and margin = 0.

## Timing
- Reset (synchronous, high at an edge):
  - state ← IDLE; out_valid = 0, class_idx = 0, max_prob = 0, terminate = 0.
  - in_ready = 0 while reset is high and 1 on the first cycle after release.
- Latency: handshake at edge T0 → SCAN occupies edges T1..TN (N = N_CLASS) → out_valid is high from just after edge TN.
  - N_CLASS = 8: out_valid rises 8 cycles after acceptance.
- out_valid held while out_ready = 0, indefinitely, with outputs unchanged.
- Handshake at edge TD with out_ready = 1: state returns to IDLE. out_valid falls and in_ready rises in the same cycle.
  - The next vector can be accepted at edge TD+1.
- Minimum issue interval: N_CLASS + 2 cycles (10 for the default).
- in_valid while not in IDLE is ignored; the upstream must hold it (standard valid/ready).
- Reset mid-SCAN or mid-DONE:
  - the in-flight vector is discarded and out_valid never asserts for it;
  - the block is ready again the cycle after reset deasserts.
- out_ready is ignored outside DONE.

## Test plan
- Reset then idle: out_valid = 0, class_idx = 0, max_prob = 0, terminate = 0; in_ready = 1 after reset release.
- Clear winner: prob = {c0..c7} = {100, 200, 50, 60000, 10, 0, 5, 30}, threshold = 40000, margin = 1000.
  - Expect out_valid exactly 8 cycles after acceptance, class_idx = 3, max_prob = 60000, terminate = 1.
- Tie / low margin: c2 = c5 = 30000, others 100, threshold = 20000, margin = 1.
  - Expect class_idx = 2, max_prob = 30000, terminate = 0 (gap 0 < 1).
- Below threshold: max 500 at c7, others ≤ 10, threshold = 1000, margin = 0.
  - Expect class_idx = 7, terminate = 0.
- Backpressure and input change:
  - Hold out_ready = 0 for 20 cycles; outputs stay constant and in_ready stays 0.
  - Change prob mid-SCAN; the result is unaffected.
  - Raise out_ready; the next vector is accepted 1 cycle later.
- Reset mid-SCAN at cnt = 4: no out_valid; a new vector accepted after release yields the correct result for that vector only.
